// File: rtl/fifo_pkg.sv
// fifo_pkg
//   Shared sizing helpers for the fifo read-side adapters and fifo_ctrl wrappers.
//   - clog2()      : ceiling log2 usable in constant expressions
//   - buf_depth()  : local skid-queue depth needed to sustain one beat per cycle
//                    across a memory read latency
//   - data_width() : byte count to bit width
package fifo_pkg;

    localparam int MIN_RD_LATENCY = 1;
    localparam int MAX_RD_LATENCY = 4;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

    // One slot per read in flight, one for the beat on the bus and one for the
    // beat that lands in the same cycle. This keeps rd_en free of any
    // combinational dependency on tready.
    function automatic int buf_depth(input int rd_latency);
        return rd_latency + 2;
    endfunction

    function automatic int data_width(input int byte_width);
        return byte_width * 8;
    endfunction

endpackage

// File: rtl/fifo_skid_queue.sv
// fifo_skid_queue
//   Small in-order register queue of DEPTH entries, each {last, data}.
//   Push and pop may happen in the same cycle. The caller guarantees that it
//   never pushes when full and never pops when empty.
// Ports
//   clk, srst        clock and synchronous active-high reset
//   push_i           write push_data_i/push_last_i at the tail
//   pop_i            drop the head entry
//   head_data_o      data of the head entry (stable until popped)
//   head_last_o      last flag of the head entry
//   occupancy_o      number of valid entries (0..DEPTH)
module fifo_skid_queue
    import fifo_pkg::*;
#(
    parameter int DW    = 8,
    parameter int DEPTH = 3,
    localparam int OW   = clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          srst,
    input  logic          push_i,
    input  logic [DW-1:0] push_data_i,
    input  logic          push_last_i,
    input  logic          pop_i,
    output logic [DW-1:0] head_data_o,
    output logic          head_last_o,
    output logic [OW-1:0] occupancy_o
);

    localparam int PW = clog2(DEPTH);
    localparam logic [PW-1:0] LAST_SLOT = PW'(DEPTH - 1);

    logic [DW:0]   slot_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [OW-1:0] occ_q, occ_d;

    // DEPTH is usually not a power of two, so pointers wrap explicitly.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
        return (ptr == LAST_SLOT) ? '0 : ptr + 1'b1;
    endfunction

    always_comb begin
        wr_ptr_d = push_i ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop_i  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        occ_d    = occ_q + OW'(push_i) - OW'(pop_i);
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (push_i) begin
                slot_q[wr_ptr_q] <= {push_last_i, push_data_i};
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    assign {head_last_o, head_data_o} = slot_q[rd_ptr_q];
    assign occupancy_o = occ_q;

endmodule

// File: rtl/fifo_rd_axis.sv
// fifo_rd_axis
//   Read-side adapter from a standard-mode (non-FWFT) fifo_ctrl + memory to an
//   AXI-Stream master. Issues rd_en on credit, tracks reads through the fixed
//   memory latency, and buffers returned words in a small skid queue.
//   Optional fixed-length framing tags tlast when a word is captured.
// Ports
//   rd_clk, rd_rst     clock and synchronous active-high reset
//   rd_en              read request to fifo_ctrl
//   rd_empty           fifo_ctrl registered empty flag
//   rd_mem_en          fifo_ctrl memory enable (rd_en that really popped)
//   rd_data            memory data, valid RD_LATENCY cycles after rd_en
//   m_axis_*           AXI-Stream master (tdata, tvalid, tready, tlast)
//   beat_count         beats captured in the current packet
module fifo_rd_axis
    import fifo_pkg::*;
#(
    parameter int BYTE_WIDTH    = 1,
    parameter int RD_LATENCY    = 1,
    parameter int PKT_LEN       = 0,
    parameter int PKT_CNT_WIDTH = 16
) (
    input  logic                               rd_clk,
    input  logic                               rd_rst,
    output logic                               rd_en,
    input  logic                               rd_empty,
    input  logic                               rd_mem_en,
    input  logic [data_width(BYTE_WIDTH)-1:0]  rd_data,
    output logic [data_width(BYTE_WIDTH)-1:0]  m_axis_tdata,
    output logic                               m_axis_tvalid,
    input  logic                               m_axis_tready,
    output logic                               m_axis_tlast,
    output logic [PKT_CNT_WIDTH-1:0]           beat_count
);

    localparam int DW        = data_width(BYTE_WIDTH);
    localparam int BUF_DEPTH = buf_depth(RD_LATENCY);
    localparam int CW        = clog2(BUF_DEPTH + 1);
    localparam logic [CW-1:0] CREDIT_MAX = CW'(BUF_DEPTH);
    localparam bit FRAMED = (PKT_LEN > 0);
    localparam logic [PKT_CNT_WIDTH-1:0] LAST_BEAT =
        FRAMED ? PKT_CNT_WIDTH'(PKT_LEN - 1) : '0;

    // credit_q = queue occupancy + reads still travelling through the memory.
    logic [CW-1:0]            credit_q, credit_d;
    // issued_q marks every rd_en; real_q marks the ones that truly popped.
    logic [RD_LATENCY-1:0]    issued_q, issued_d;
    logic [RD_LATENCY-1:0]    real_q, real_d;
    logic [PKT_CNT_WIDTH-1:0] beat_q, beat_d;
    logic [CW-1:0]            occupancy;
    logic                     push, phantom, pop, tag_last;

    // rd_empty is registered in fifo_ctrl and credit_q is local state, so
    // there is no path from tready to rd_en.
    assign rd_en = !rd_empty && (credit_q < CREDIT_MAX) && !rd_rst;

    always_comb begin
        issued_d = (issued_q << 1) | RD_LATENCY'(rd_en);
        real_d   = (real_q << 1)   | RD_LATENCY'(rd_en & rd_mem_en);

        push     = real_q[RD_LATENCY-1];
        // A read issued during the empty-flag lag returns nothing; it only
        // has to give its credit back.
        phantom  = issued_q[RD_LATENCY-1] & ~real_q[RD_LATENCY-1];
        pop      = m_axis_tvalid & m_axis_tready;

        credit_d = credit_q + CW'(rd_en) - CW'(pop) - CW'(phantom);

        tag_last = FRAMED && (beat_q == LAST_BEAT);
        beat_d   = beat_q;
        if (FRAMED && push) begin
            beat_d = tag_last ? '0 : beat_q + 1'b1;
        end
    end

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            credit_q <= '0;
            issued_q <= '0;
            real_q   <= '0;
            beat_q   <= '0;
        end else begin
            credit_q <= credit_d;
            issued_q <= issued_d;
            real_q   <= real_d;
            beat_q   <= beat_d;
        end
    end

    fifo_skid_queue #(
        .DW    (DW),
        .DEPTH (BUF_DEPTH)
    ) u_queue (
        .clk         (rd_clk),
        .srst        (rd_rst),
        .push_i      (push),
        .push_data_i (rd_data),
        .push_last_i (tag_last),
        .pop_i       (pop),
        .head_data_o (m_axis_tdata),
        .head_last_o (m_axis_tlast),
        .occupancy_o (occupancy)
    );

    assign m_axis_tvalid = (occupancy != '0);
    assign beat_count    = beat_q;

endmodule

// File: tb/tb_fifo_rd_axis.sv
// tb_fifo_rd_axis
//   Drives fifo_rd_axis (RD_LATENCY=1) from a behavioural fifo whose empty
//   flag lags one cycle, so phantom reads occur at the end of every burst.
//   u_dut uses PKT_LEN=4, u_dut1 uses PKT_LEN=1 with the same stimulus.
module tb_fifo_rd_axis;

    localparam int DW  = 8;
    localparam int PCW = 16;

    logic           rd_clk = 1'b0;
    logic           rd_rst = 1'b1;
    logic           force_ne = 1'b1;
    logic           model_empty = 1'b1;
    logic           rd_empty, rd_mem_en;
    logic [DW-1:0]  rd_data = '0;
    logic           tready = 1'b1;

    logic           rd_en, rd_en_1;
    logic [DW-1:0]  tdata, tdata_1;
    logic           tvalid, tvalid_1, tlast, tlast_1;
    logic [PCW-1:0] bc, bc_1;

    logic [DW-1:0]  fmem [64];
    int unsigned    head = 0;
    int unsigned    tail = 0;

    int n_checks = 0;
    int n_fail   = 0;
    int main_idx = 0;

    always #5 rd_clk = ~rd_clk;

    // Behavioural fifo_ctrl + memory: registered empty computed from the
    // pre-pop count, one-cycle registered read.
    assign rd_empty  = model_empty & ~force_ne;
    assign rd_mem_en = rd_en && (tail != head);

    always @(posedge rd_clk) begin
        if (rd_mem_en) begin
            rd_data <= fmem[head[5:0]];
            head    <= head + 1;
        end
        model_empty <= (tail == head);
    end

    fifo_rd_axis #(.BYTE_WIDTH(1), .RD_LATENCY(1), .PKT_LEN(4), .PKT_CNT_WIDTH(PCW)) u_dut (
        .rd_clk(rd_clk), .rd_rst(rd_rst), .rd_en(rd_en), .rd_empty(rd_empty),
        .rd_mem_en(rd_mem_en), .rd_data(rd_data), .m_axis_tdata(tdata),
        .m_axis_tvalid(tvalid), .m_axis_tready(tready), .m_axis_tlast(tlast),
        .beat_count(bc)
    );

    fifo_rd_axis #(.BYTE_WIDTH(1), .RD_LATENCY(1), .PKT_LEN(1), .PKT_CNT_WIDTH(PCW)) u_dut1 (
        .rd_clk(rd_clk), .rd_rst(rd_rst), .rd_en(rd_en_1), .rd_empty(rd_empty),
        .rd_mem_en(rd_mem_en), .rd_data(rd_data), .m_axis_tdata(tdata_1),
        .m_axis_tvalid(tvalid_1), .m_axis_tready(tready), .m_axis_tlast(tlast_1),
        .beat_count(bc_1)
    );

    typedef struct {
        logic           rst;
        logic           ne;
        logic           wr;
        logic [DW-1:0]  wdata;
        logic           exp_rd_en;
        logic           exp_tvalid;
        logic           chk_data;
        logic [DW-1:0]  exp_tdata;
        logic           exp_tlast;
        logic [PCW-1:0] exp_bc;
        logic           exp_tlast_1;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge rd_clk);
        #1;
    endtask

    task automatic sample();
        @(negedge rd_clk);
    endtask

    task automatic write_word(input logic [DW-1:0] v);
        fmem[tail[5:0]] = v;
        tail = tail + 1;
    endtask

    task automatic do_reset();
        step();
        rd_rst = 1'b1;
        step();
        step();
        rd_rst = 1'b0;
        main_idx = 0;
    endtask

    // Entered and left in the drive phase (just after a rising edge).
    task automatic collect(input int n, input int first, input int bound);
        int got;
        int waited;
        got = 0;
        waited = 0;
        while (got < n && waited < bound) begin
            sample();
            if (tvalid && tready) begin
                check("beat_data", tdata, first + got);
                check("beat_tlast", tlast, ((main_idx % 4) == 3));
                check("beat_valid_1", tvalid_1, 1);
                check("beat_data_1", tdata_1, first + got);
                check("beat_tlast_1", tlast_1, 1);
                $display("beat %0d: tdata=0x%0h tlast=%0b", main_idx, tdata, tlast);
                got++;
                main_idx++;
            end
            step();
            waited++;
        end
        check("beats_received", got, n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int fall;
        int pulses;
        int extra;

        // rst ne wr wdata | rd_en tvalid chk tdata tlast bc tlast_1
        vecs[0] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 16'd0, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 16'd0, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 16'd0, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 16'd0, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 16'd0, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 16'd0, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 16'd0, 1'b0};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 16'd1, 1'b1};
        vecs[8] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 16'd1, 1'b0};

        // Reset hold, then a single word: real read, phantom read, one beat.
        for (int i = 0; i < 9; i++) begin
            step();
            rd_rst   = vecs[i].rst;
            force_ne = vecs[i].ne;
            if (vecs[i].wr) write_word(vecs[i].wdata);
            sample();
            check("vec_rd_en", rd_en, vecs[i].exp_rd_en);
            check("vec_rd_en_1", rd_en_1, vecs[i].exp_rd_en);
            check("vec_tvalid", tvalid, vecs[i].exp_tvalid);
            if (vecs[i].chk_data) check("vec_tdata", tdata, vecs[i].exp_tdata);
            check("vec_tlast", tlast, vecs[i].exp_tlast);
            check("vec_beat_count", bc, vecs[i].exp_bc);
            check("vec_tlast_1", tlast_1, vecs[i].exp_tlast_1);
            check("vec_beat_count_1", bc_1, 0);
            $display("vec %0d: rd_en=%0b tvalid=%0b tdata=0x%0h tlast=%0b beat_count=%0d",
                     i, rd_en, tvalid, tdata, tlast, bc);
        end

        // Streaming 16 words at full rate.
        do_reset();
        tready = 1'b1;
        for (int i = 0; i < 16; i++) write_word(8'(i));
        fall = -1;
        for (int c = 0; c < 10; c++) begin
            sample();
            if (!rd_empty) begin
                fall = c;
                break;
            end
            step();
        end
        check("t2_empty_fall_seen", (fall >= 0), 1);
        check("t2_rd_en_on_fall", rd_en, 1);
        step();
        sample();
        check("t2_tvalid_latency_early", tvalid, 0);
        for (int i = 0; i < 16; i++) begin
            step();
            sample();
            check("t2_stream_valid", tvalid, 1);
            check("t2_stream_data", tdata, i);
            check("t2_stream_tlast", tlast, ((main_idx % 4) == 3));
            check("t2_stream_tlast_1", tlast_1, 1);
            $display("beat %0d: tdata=0x%0h tlast=%0b", main_idx, tdata, tlast);
            main_idx++;
        end

        // Backpressure: 16 more words with tready low.
        step();
        tready = 1'b0;
        for (int i = 16; i < 32; i++) write_word(8'(i));
        sample();
        check("t2_no_extra_beat", tvalid, 0);
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
            if (rd_en) pulses++;
            if (tvalid) check("t3_hold_data", tdata, 16);
            step();
            sample();
        end
        check("t3_rd_en_pulses", pulses, 3);
        check("t3_rd_en_idle", rd_en, 0);
        check("t3_tvalid_held", tvalid, 1);
        step();
        tready = 1'b1;
        collect(16, 16, 80);

        // Framing: 10 words, tlast on beats 3 and 7.
        do_reset();
        tready = 1'b1;
        for (int i = 0; i < 10; i++) write_word(8'(8'h40 + i));
        collect(10, 8'h40, 60);
        sample();
        check("t5_beat_count_end", bc, 2);
        check("t5_beat_count_end_1", bc_1, 0);

        // Reset with two beats buffered and one read in flight.
        do_reset();
        tready = 1'b0;
        for (int i = 0; i < 8; i++) write_word(8'(8'h80 + i));
        step();
        step();
        step();
        step();
        rd_rst = 1'b1;
        sample();
        check("t6_pre_tvalid", tvalid, 1);
        check("t6_pre_tdata", tdata, 8'h80);
        check("t6_pre_beat_count", bc, 2);
        check("t6_pre_rd_en", rd_en, 0);
        step();
        rd_rst = 1'b0;
        tready = 1'b1;
        main_idx = 0;
        sample();
        check("t6_post_tvalid", tvalid, 0);
        check("t6_post_beat_count", bc, 0);
        check("t6_post_beat_count_1", bc_1, 0);
        step();
        collect(5, 8'h83, 40);
        extra = 0;
        for (int c = 0; c < 6; c++) begin
            sample();
            if (tvalid) extra++;
            step();
        end
        check("t6_no_extra_beats", extra, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
